y86_pipe_ctrl: RTL and testbench

- Pipeline control unit for the five-stage Y86-64 core.
- Generates stall and bubble controls for the F/D/E/M/W pipeline registers.
- Detects load/use, ret and mispredicted-branch hazards, which sets the sequencing that fetch PC selection depends on.
- Holds the processor run state (RUN/DRAIN/HALTED) and the architectural status register; optionally keeps performance counters.

---
 rtl/y86_pipe_ctrl_if.sv | 35 +++
 rtl/y86_pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_y86_pipe_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/y86_pipe_ctrl_if.sv
// y86_pipe_ctrl_if: hazard inputs and pipeline-register controls exchanged
// between the Y86-64 datapath (master) and the pipeline control unit (slave).
`default_nettype none

interface y86_pipe_ctrl_if;
  logic [3:0] D_icode;
  logic [3:0] E_icode;
  logic [3:0] M_icode;
  logic [3:0] E_dstM;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic       e_cnd;
  logic [2:0] m_stat;
  logic [2:0] W_stat;
  logic       F_stall;
  logic       D_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_stall;
  logic [2:0] cpu_stat;
  logic       halted;

  modport master (
    output D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_cnd, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, cpu_stat, halted
  );

  modport slave (
    input  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_cnd, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, cpu_stat, halted
  );
endinterface

`default_nettype wire

// File: rtl/y86_pipe_ctrl.sv
// y86_pipe_ctrl: stall/bubble generation, run state and status register for the
// five-stage Y86-64 pipeline. Define Y86_PIPE_PERF_EN to add performance counters.
`default_nettype none

module y86_pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  y86_pipe_ctrl_if.slave ctl
`ifdef Y86_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_stalls,
  output logic [CNT_W-1:0] perf_mispred
`endif
);

  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] cpu_stat_r;

  logic loaduse, retp, mispred, exc_m, exc_w;

  always_comb begin
    loaduse = ((ctl.E_icode == I_MRMOVQ) || (ctl.E_icode == I_POPQ)) &&
              (ctl.E_dstM != R_NONE) &&
              ((ctl.E_dstM == ctl.d_srcA) || (ctl.E_dstM == ctl.d_srcB));
    retp    = (ctl.D_icode == I_RET) || (ctl.E_icode == I_RET) || (ctl.M_icode == I_RET);
    mispred = (ctl.E_icode == I_JXX) && !ctl.e_cnd;
    exc_m   = (ctl.m_stat == S_HLT) || (ctl.m_stat == S_ADR) || (ctl.m_stat == S_INS);
    exc_w   = (ctl.W_stat == S_HLT) || (ctl.W_stat == S_ADR) || (ctl.W_stat == S_INS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cpu_stat_r <= S_AOK;
    end else begin
      state <= state_nxt;
      // A zero status marks a bubble in W and carries no architectural meaning.
      if (state != HALTED && ctl.W_stat != 3'd0)
        cpu_stat_r <= ctl.W_stat;
    end
  end

  always_comb begin
    state_nxt    = state;
    ctl.F_stall  = 1'b0;
    ctl.D_stall  = 1'b0;
    ctl.D_bubble = 1'b0;
    ctl.E_bubble = 1'b0;
    ctl.M_bubble = 1'b0;
    ctl.W_stall  = 1'b0;

    case (state)
      RUN: begin
        if (exc_w)      state_nxt = HALTED;
        else if (exc_m) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (exc_w) state_nxt = HALTED;
      end
      default: state_nxt = HALTED;
    endcase

    if (rst) begin
      ctl.D_bubble = 1'b1;
      ctl.E_bubble = 1'b1;
      ctl.M_bubble = 1'b1;
    end else if (state == HALTED) begin
      ctl.F_stall  = 1'b1;
      ctl.D_stall  = 1'b1;
      ctl.M_bubble = 1'b1;
      ctl.W_stall  = 1'b1;
    end else begin
      // Load/use takes priority over ret so D is never both held and bubbled.
      ctl.F_stall  = loaduse | retp;
      ctl.D_stall  = loaduse;
      ctl.D_bubble = mispred | (retp & ~loaduse);
      ctl.E_bubble = mispred | loaduse;
      ctl.M_bubble = exc_m | exc_w;
      ctl.W_stall  = exc_w;
    end
  end

  assign ctl.cpu_stat = cpu_stat_r;
  assign ctl.halted   = (state == HALTED);

`ifdef Y86_PIPE_PERF_EN
  logic active;
  assign active = (state != HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_mispred <= '0;
    end else begin
      if (active)                        perf_cycles  <= perf_cycles + 1'b1;
      if (active && (loaduse || retp))   perf_stalls  <= perf_stalls + 1'b1;
      if (active && mispred)             perf_mispred <= perf_mispred + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_y86_pipe_ctrl.sv
// tb_y86_pipe_ctrl: directed hand-computed vectors for y86_pipe_ctrl.
`default_nettype none

module tb_y86_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  y86_pipe_ctrl_if bus ();

`ifdef Y86_PIPE_PERF_EN
  logic [3:0] perf_cycles, perf_stalls, perf_mispred;
  y86_pipe_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ctl(bus.slave),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .perf_mispred(perf_mispred)
  );
`else
  y86_pipe_ctrl dut (.clk(clk), .rst(rst), .ctl(bus.slave));
`endif

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  logic [5:0] ctlv;
  assign ctlv = {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_stall};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.D_icode = 4'h1; bus.E_icode = 4'h1; bus.M_icode = 4'h1;
    bus.E_dstM = 4'hF; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    bus.e_cnd = 1'b0; bus.m_stat = 3'd1; bus.W_stat = 3'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 check("rst_ctl", {26'd0, ctlv}, 32'b001110);
    tick();
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_stat", {29'd0, bus.cpu_stat}, 32'd1);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    do_reset();
    #1 check("idle_ctl", {26'd0, ctlv}, 32'b000000);

    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    #1 check("loaduse_mrmov_srcA", {26'd0, ctlv}, 32'b110100);
    bus.E_icode = 4'hB; bus.d_srcA = 4'hF; bus.d_srcB = 4'h3;
    #1 check("loaduse_pop_srcB", {26'd0, ctlv}, 32'b110100);
    bus.E_dstM = 4'hF; bus.d_srcB = 4'hF;
    #1 check("dstM_none_no_hazard", {26'd0, ctlv}, 32'b000000);
    bus.E_icode = 4'hC; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    #1 check("unknown_icode", {26'd0, ctlv}, 32'b000000);

    idle();
    bus.E_icode = 4'h7; bus.e_cnd = 1'b0;
    #1 check("mispred", {26'd0, ctlv}, 32'b001100);
    bus.e_cnd = 1'b1;
    #1 check("jxx_taken_ok", {26'd0, ctlv}, 32'b000000);

    idle();
    bus.D_icode = 4'h9;
    #1 check("ret_D", {26'd0, ctlv}, 32'b101000);
    tick();
    bus.D_icode = 4'h1; bus.E_icode = 4'h9;
    #1 check("ret_E", {26'd0, ctlv}, 32'b101000);
    tick();
    bus.E_icode = 4'h1; bus.M_icode = 4'h9;
    #1 check("ret_M", {26'd0, ctlv}, 32'b101000);
    tick();
    idle();
    bus.D_icode = 4'h9; bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    #1 check("ret_plus_loaduse", {26'd0, ctlv}, 32'b110100);

    idle();
    bus.W_stat = 3'd0;
    tick();
    check("wstat0_keeps_stat", {29'd0, bus.cpu_stat}, 32'd1);

    // Exception drains through M then halts on W.
    idle();
    bus.m_stat = 3'd3;
    #1 check("exc_m_ctl", {26'd0, ctlv}, 32'b000010);
    tick();
    check("drain_not_halted", {31'd0, bus.halted}, 32'd0);
    bus.m_stat = 3'd1;
    #1 check("drain_no_return_loaduse_free", {26'd0, ctlv}, 32'b000000);
    tick();
    check("drain_holds", {31'd0, bus.halted}, 32'd0);
    bus.W_stat = 3'd3;
    #1 check("exc_w_ctl", {26'd0, ctlv}, 32'b000011);
    tick();
    check("halted_set", {31'd0, bus.halted}, 32'd1);
    check("halted_stat", {29'd0, bus.cpu_stat}, 32'd3);
    bus.W_stat = 3'd4; bus.E_icode = 4'h7; bus.e_cnd = 1'b0; bus.D_icode = 4'h9;
    #1 check("halted_ctl", {26'd0, ctlv}, 32'b110011);
    tick();
    check("halted_stat_frozen", {29'd0, bus.cpu_stat}, 32'd3);
    check("halted_sticky", {31'd0, bus.halted}, 32'd1);
    do_reset();

    idle();
    bus.W_stat = 3'd2;
    tick();
    check("hlt_halted", {31'd0, bus.halted}, 32'd1);
    check("hlt_stat", {29'd0, bus.cpu_stat}, 32'd2);
    idle();
    do_reset();

    bus.m_stat = 3'd3; bus.W_stat = 3'd4;
    tick();
    check("simul_exc_halted", {31'd0, bus.halted}, 32'd1);
    check("simul_exc_stat", {29'd0, bus.cpu_stat}, 32'd4);
    idle();
    do_reset();

`ifdef Y86_PIPE_PERF_EN
    for (int i = 0; i < 20; i++) begin
      idle();
      if (i == 2 || i == 5 || i == 8) begin
        bus.E_icode = 4'h5; bus.E_dstM = 4'h2; bus.d_srcB = 4'h2;
      end
      if (i == 11 || i == 14) begin
        bus.E_icode = 4'h7; bus.e_cnd = 1'b0;
      end
      tick();
    end
    check("perf_cycles_wrap", {28'd0, perf_cycles}, 32'd4);
    check("perf_stalls", {28'd0, perf_stalls}, 32'd3);
    check("perf_mispred", {28'd0, perf_mispred}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
